// File: rtl/barrett_divmod_pipe.sv
// ----------------------------------------------------------------------------
// barrett_divmod_pipe
//
// Streaming Barrett divider. For each accepted transaction it produces
// dividend / m0 and dividend % m0, using a caller-supplied reciprocal
// m0_inverse = floor(2^SHIFT / m0). Three register stages:
//   S1  q0 = (dividend * m0_inverse) >> SHIFT      (estimate, never too large
//                                                   when the inverse is exact)
//   S2  r0 = dividend - q0 * m0                    (residual of the estimate)
//   S3  up to CORR conditional subtractions of m0, then flag evaluation,
//       registered straight into the output port registers.
// All stages advance together on en = !out_valid | out_ready, so a stalled
// consumer freezes the whole pipe and nothing is ever dropped or duplicated.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   in_valid/ready  input handshake; in_ready is combinational from out_ready
//   in_dividend     2*M0LEN-bit dividend
//   in_m0           M0LEN-bit divisor
//   in_m0_inverse   SHIFT-bit reciprocal floor(2^SHIFT / in_m0)
//   in_tag          sideband returned unchanged with the result
//   out_valid/ready output handshake
//   out_quotient    M0LEN-bit quotient (all ones on divide-by-zero)
//   out_remainder   M0LEN-bit remainder (dividend low bits on divide-by-zero)
//   out_tag         tag of the presented result
//   out_ovf         quotient did not fit, or residual still >= m0 after CORR
//   out_dz          divisor was zero
// ----------------------------------------------------------------------------
module barrett_divmod_pipe #(
  parameter int M0LEN = 14,
  parameter int SHIFT = 27,
  parameter int TAGW  = 8,
  parameter int CORR  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*M0LEN-1:0]   in_dividend,
  input  logic [M0LEN-1:0]     in_m0,
  input  logic [SHIFT-1:0]     in_m0_inverse,
  input  logic [TAGW-1:0]      in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [M0LEN-1:0]     out_quotient,
  output logic [M0LEN-1:0]     out_remainder,
  output logic [TAGW-1:0]      out_tag,
  output logic                 out_ovf,
  output logic                 out_dz
);

  localparam int DW = 2 * M0LEN;       // dividend width
  localparam int QW = DW + 1;          // estimate / residual width
  localparam int PW = DW + SHIFT;      // full dividend * inverse product
  localparam int MW = QW + M0LEN;      // full q0 * m0 product

  localparam logic [QW-1:0] Q_ONE = {{(QW - 1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // Flow control
  // --------------------------------------------------------------------------
  logic en_s;
  logic out_valid_q;

  assign en_s     = !out_valid_q || out_ready;
  assign in_ready = en_s;

  // --------------------------------------------------------------------------
  // Stage 1: quotient estimate
  // --------------------------------------------------------------------------
  logic [PW-1:0]    prod_s;
  logic [QW-1:0]    s1_q0_d;
  logic             s1_dz_d;
  logic             unused_prod_low_s;

  logic             s1_valid_q;
  logic [DW-1:0]    s1_dividend_q;
  logic [M0LEN-1:0] s1_m0_q;
  logic [QW-1:0]    s1_q0_q;
  logic [TAGW-1:0]  s1_tag_q;
  logic             s1_dz_q;

  // Full-width product; only the bits above SHIFT form the estimate.
  assign prod_s            = PW'(in_dividend) * PW'(in_m0_inverse);
  assign s1_q0_d           = {1'b0, prod_s[PW-1:SHIFT]};
  assign unused_prod_low_s = ^prod_s[SHIFT-1:0];
  assign s1_dz_d           = (in_m0 == {M0LEN{1'b0}});

  // Stage 1 registers: valid follows the input handshake, data loads only on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_dividend_q <= {DW{1'b0}};
      s1_m0_q       <= {M0LEN{1'b0}};
      s1_q0_q       <= {QW{1'b0}};
      s1_tag_q      <= {TAGW{1'b0}};
      s1_dz_q       <= 1'b0;
    end else if (en_s) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_dividend_q <= in_dividend;
        s1_m0_q       <= in_m0;
        s1_q0_q       <= s1_q0_d;
        s1_tag_q      <= in_tag;
        s1_dz_q       <= s1_dz_d;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: residual of the estimate
  // --------------------------------------------------------------------------
  logic [MW-1:0]    qm_s;
  logic [MW-1:0]    diff_s;
  logic [QW-1:0]    s2_r0_d;
  logic             s2_big_d;

  logic             s2_valid_q;
  logic [M0LEN-1:0] s2_m0_q;
  logic [QW-1:0]    s2_q_q;
  logic [QW-1:0]    s2_r0_q;
  logic [TAGW-1:0]  s2_tag_q;
  logic             s2_dz_q;
  logic             s2_big_q;

  // The difference is taken at full product width. With a too-large inverse
  // it goes negative and wraps; any set bit above QW marks the residual as
  // unrepresentable so the result is flagged instead of silently wrong.
  assign qm_s     = MW'(s1_q0_q) * MW'(s1_m0_q);
  assign diff_s   = MW'(s1_dividend_q) - qm_s;
  assign s2_r0_d  = diff_s[QW-1:0];
  assign s2_big_d = |diff_s[MW-1:QW];

  // Stage 2 registers: advance with the pipe, data loads only behind a valid stage 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_m0_q    <= {M0LEN{1'b0}};
      s2_q_q     <= {QW{1'b0}};
      s2_r0_q    <= {QW{1'b0}};
      s2_tag_q   <= {TAGW{1'b0}};
      s2_dz_q    <= 1'b0;
      s2_big_q   <= 1'b0;
    end else if (en_s) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_m0_q  <= s1_m0_q;
        s2_q_q   <= s1_q0_q;
        s2_r0_q  <= s2_r0_d;
        s2_tag_q <= s1_tag_q;
        s2_dz_q  <= s1_dz_q;
        s2_big_q <= s2_big_d;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 3: correction and flag evaluation
  // --------------------------------------------------------------------------
  logic [QW-1:0]    m0_ext_s;
  logic [QW-1:0]    corr_q_s;
  logic [QW-1:0]    corr_r_s;
  logic [M0LEN-1:0] out_quotient_d;
  logic [M0LEN-1:0] out_remainder_d;
  logic             out_ovf_d;

  logic [M0LEN-1:0] out_quotient_q;
  logic [M0LEN-1:0] out_remainder_q;
  logic [TAGW-1:0]  out_tag_q;
  logic             out_ovf_q;
  logic             out_dz_q;

  assign m0_ext_s = {{(QW - M0LEN){1'b0}}, s2_m0_q};

  // Unrolled conditional subtraction chain, CORR steps deep
  always_comb begin
    corr_q_s = s2_q_q;
    corr_r_s = s2_r0_q;
    for (int i = 0; i < CORR; i++) begin
      if (corr_r_s >= m0_ext_s) begin
        corr_r_s = corr_r_s - m0_ext_s;
        corr_q_s = corr_q_s + Q_ONE;
      end else begin
        corr_r_s = corr_r_s;
        corr_q_s = corr_q_s;
      end
    end
  end

  // Output selection: divide-by-zero overrides, otherwise report truncated
  // values with a flag whenever the reduction did not complete
  always_comb begin
    out_quotient_d  = corr_q_s[M0LEN-1:0];
    out_remainder_d = corr_r_s[M0LEN-1:0];
    out_ovf_d       = 1'b0;
    if (s2_dz_q) begin
      // m0 = 0 leaves r0 equal to the dividend regardless of the estimate
      out_quotient_d  = {M0LEN{1'b1}};
      out_remainder_d = s2_r0_q[M0LEN-1:0];
      out_ovf_d       = 1'b0;
    end else begin
      out_quotient_d  = corr_q_s[M0LEN-1:0];
      out_remainder_d = corr_r_s[M0LEN-1:0];
      out_ovf_d       = (|corr_q_s[QW-1:M0LEN]) || (corr_r_s >= m0_ext_s) || s2_big_q;
    end
  end

  // Output registers: hold while the consumer stalls, load only behind a valid stage 2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q     <= 1'b0;
      out_quotient_q  <= {M0LEN{1'b0}};
      out_remainder_q <= {M0LEN{1'b0}};
      out_tag_q       <= {TAGW{1'b0}};
      out_ovf_q       <= 1'b0;
      out_dz_q        <= 1'b0;
    end else if (en_s) begin
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        out_quotient_q  <= out_quotient_d;
        out_remainder_q <= out_remainder_d;
        out_tag_q       <= s2_tag_q;
        out_ovf_q       <= out_ovf_d;
        out_dz_q        <= s2_dz_q;
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign out_quotient  = out_quotient_q;
  assign out_remainder = out_remainder_q;
  assign out_tag       = out_tag_q;
  assign out_ovf       = out_ovf_q;
  assign out_dz        = out_dz_q;

endmodule

// File: tb/tb_barrett_divmod_pipe.sv
// ----------------------------------------------------------------------------
// tb_barrett_divmod_pipe
//
// Scoreboard bench for barrett_divmod_pipe. Two instances share the input
// stream: one with two correction steps, one with a single step. The driver
// pushes hand-computed results for both on every input handshake; separate
// monitors pop and compare whenever an instance presents an accepted result.
// ----------------------------------------------------------------------------
module tb_barrett_divmod_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_ready1;
  logic [27:0] in_dividend;
  logic [13:0] in_m0;
  logic [26:0] in_m0_inverse;
  logic [7:0]  in_tag;
  logic        out_ready;

  logic        out_valid,     out_valid1;
  logic [13:0] out_quotient,  out_quotient1;
  logic [13:0] out_remainder, out_remainder1;
  logic [7:0]  out_tag,       out_tag1;
  logic        out_ovf,       out_ovf1;
  logic        out_dz,        out_dz1;

  typedef struct {
    logic [13:0] q;
    logic [13:0] r;
    logic [7:0]  tag;
    logic        ovf;
    logic        dz;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t sb2[$];
  exp_t sb1[$];
  exp_t m2_e;
  exp_t m1_e;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  barrett_divmod_pipe #(.M0LEN(14), .SHIFT(27), .TAGW(8), .CORR(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_m0(in_m0), .in_m0_inverse(in_m0_inverse), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_remainder(out_remainder), .out_tag(out_tag),
    .out_ovf(out_ovf), .out_dz(out_dz)
  );

  barrett_divmod_pipe #(.M0LEN(14), .SHIFT(27), .TAGW(8), .CORR(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready1),
    .in_dividend(in_dividend), .in_m0(in_m0), .in_m0_inverse(in_m0_inverse), .in_tag(in_tag),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_quotient(out_quotient1), .out_remainder(out_remainder1), .out_tag(out_tag1),
    .out_ovf(out_ovf1), .out_dz(out_dz1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present one transaction, wait (bounded) for acceptance, record expectations.
  task automatic send(input logic [27:0] d, input logic [13:0] m, input logic [26:0] inv,
                      input logic [7:0] tag,
                      input logic [13:0] q2, input logic [13:0] r2, input logic ovf2, input logic dz,
                      input logic [13:0] q1, input logic [13:0] r1, input logic ovf1,
                      input bit lat, input bit push);
    exp_t e;
    int   w;
    in_valid      = 1'b1;
    in_dividend   = d;
    in_m0         = m;
    in_m0_inverse = inv;
    in_tag        = tag;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 60) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: tag %0d never accepted", tag);
    end else if (push) begin
      e.q = q2; e.r = r2; e.tag = tag; e.ovf = ovf2; e.dz = dz; e.acc = cyc; e.lat = lat;
      sb2.push_back(e);
      e.q = q1; e.r = r1; e.ovf = ovf1;
      sb1.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sb2.size() != 0 || sb1.size() != 0) && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (sb2.size() != 0 || sb1.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: pending c2=%0d c1=%0d", sb2.size(), sb1.size());
    end
  endtask

  // Monitor for the two-step instance
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb2.size() == 0) begin
        total++;
        bad++;
        $display("FAIL c2_unexpected: q=%0d r=%0d tag=%0d with nothing expected",
                 out_quotient, out_remainder, out_tag);
      end else begin
        m2_e = sb2.pop_front();
        chk("c2_quotient",  {18'd0, out_quotient},  {18'd0, m2_e.q});
        chk("c2_remainder", {18'd0, out_remainder}, {18'd0, m2_e.r});
        chk("c2_tag",       {24'd0, out_tag},       {24'd0, m2_e.tag});
        chk("c2_ovf",       {31'd0, out_ovf},       {31'd0, m2_e.ovf});
        chk("c2_dz",        {31'd0, out_dz},        {31'd0, m2_e.dz});
        if (m2_e.lat) chk("c2_latency", cyc - m2_e.acc, 32'd3);
      end
    end
  end

  // Monitor for the one-step instance
  always @(negedge clk) begin
    if (!rst && out_valid1 && out_ready) begin
      if (sb1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL c1_unexpected: q=%0d r=%0d tag=%0d with nothing expected",
                 out_quotient1, out_remainder1, out_tag1);
      end else begin
        m1_e = sb1.pop_front();
        chk("c1_quotient",  {18'd0, out_quotient1},  {18'd0, m1_e.q});
        chk("c1_remainder", {18'd0, out_remainder1}, {18'd0, m1_e.r});
        chk("c1_tag",       {24'd0, out_tag1},       {24'd0, m1_e.tag});
        chk("c1_ovf",       {31'd0, out_ovf1},       {31'd0, m1_e.ovf});
        chk("c1_dz",        {31'd0, out_dz1},        {31'd0, m1_e.dz});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    in_valid      = 1'b0;
    in_dividend   = 28'd0;
    in_m0         = 14'd0;
    in_m0_inverse = 27'd0;
    in_tag        = 8'd0;
    out_ready     = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid",  {31'd0, out_valid},      32'd0);
    chk("rst_quotient",   {18'd0, out_quotient},   32'd0);
    chk("rst_remainder",  {18'd0, out_remainder},  32'd0);
    chk("rst_tag",        {24'd0, out_tag},        32'd0);
    chk("rst_ovf_dz",     {30'd0, out_ovf, out_dz}, 32'd0);
    chk("rst_in_ready",   {31'd0, in_ready},       32'd1);
    chk("rst_c1_valid",   {31'd0, out_valid1},     32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 4591 * 4590 = 21072690 exactly
    send(28'd21072690, 14'd4591, 27'd29234, 8'h5A, 14'd4590, 14'd0, 1'b0, 1'b0,
         14'd4590, 14'd0, 1'b0, 1'b1, 1'b1);
    drain();

    // Back-to-back pair, each with the 3-cycle latency
    @(posedge clk);
    #1;
    send(28'd0,    14'd4591, 27'd29234, 8'h01, 14'd0, 14'd0,    1'b0, 1'b0, 14'd0, 14'd0,    1'b0, 1'b1, 1'b1);
    send(28'd4590, 14'd4591, 27'd29234, 8'h02, 14'd0, 14'd4590, 1'b0, 1'b0, 14'd0, 14'd4590, 1'b0, 1'b1, 1'b1);
    drain();

    // Consumer stalled for 5 cycles while four inputs arrive
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    fork
      begin
        send(28'd4591,  14'd4591, 27'd29234, 8'h10, 14'd1, 14'd0,    1'b0, 1'b0, 14'd1, 14'd0,    1'b0, 1'b0, 1'b1);
        send(28'd9182,  14'd4591, 27'd29234, 8'h11, 14'd2, 14'd0,    1'b0, 1'b0, 14'd2, 14'd0,    1'b0, 1'b0, 1'b1);
        send(28'd9183,  14'd4591, 27'd29234, 8'h12, 14'd2, 14'd1,    1'b0, 1'b0, 14'd2, 14'd1,    1'b0, 1'b0, 1'b1);
        send(28'd13772, 14'd4591, 27'd29234, 8'h13, 14'd2, 14'd4590, 1'b0, 1'b0, 14'd2, 14'd4590, 1'b0, 1'b0, 1'b1);
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("stall_in_ready",    {31'd0, in_ready},     32'd0);
        chk("stall_c1_in_ready", {31'd0, in_ready1},    32'd0);
        chk("stall_out_valid",   {31'd0, out_valid},    32'd1);
        chk("stall_hold_q",      {18'd0, out_quotient}, 32'd1);
        chk("stall_hold_tag",    {24'd0, out_tag},      32'h10);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Flag and correction-depth cases, streamed back to back
    @(posedge clk);
    #1;
    // 4591 * 16384: quotient does not fit in 14 bits
    send(28'd75218944, 14'd4591, 27'd29234, 8'h20, 14'd0, 14'd0, 1'b1, 1'b0, 14'd0, 14'd0, 1'b1, 1'b0, 1'b1);
    // divide by zero
    send(28'd1000, 14'd0, 27'd0, 8'h21, 14'h3FFF, 14'd1000, 1'b0, 1'b1, 14'h3FFF, 14'd1000, 1'b0, 1'b0, 1'b1);
    // inverse one low: estimate 4589, residual 4591, one step suffices
    send(28'd21072690, 14'd4591, 27'd29233, 8'h22, 14'd4590, 14'd0, 1'b0, 1'b0, 14'd4590, 14'd0, 1'b0, 1'b0, 1'b1);
    // estimate 98, residual 9182 = 2*m0: two steps exact, one step flags
    send(28'd459100, 14'd4591, 27'd28651, 8'h23, 14'd100, 14'd0, 1'b0, 1'b0, 14'd99, 14'd4591, 1'b1, 1'b0, 1'b1);
    // estimate 4553, residual 169867: both depths flag with truncated values
    send(28'd21072690, 14'd4591, 27'd29000, 8'h24, 14'd4555, 14'd13229, 1'b1, 1'b0, 14'd4554, 14'd1436, 1'b1, 1'b0, 1'b1);
    drain();

    // Reset with three transactions in flight: none may emerge
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(28'd4591, 14'd4591, 27'd29234, 8'h40, 14'd0, 14'd0, 1'b0, 1'b0, 14'd0, 14'd0, 1'b0, 1'b0, 1'b0);
    send(28'd9182, 14'd4591, 27'd29234, 8'h41, 14'd0, 14'd0, 1'b0, 1'b0, 14'd0, 14'd0, 1'b0, 1'b0, 1'b0);
    send(28'd9183, 14'd4591, 27'd29234, 8'h42, 14'd0, 14'd0, 1'b0, 1'b0, 14'd0, 14'd0, 1'b0, 1'b0, 1'b0);
    chk("inflight_out_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid",    {31'd0, out_valid},    32'd0);
    chk("midrst_c1_out_valid", {31'd0, out_valid1},   32'd0);
    chk("midrst_quotient",     {18'd0, out_quotient}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("postrst_idle", {30'd0, out_valid, out_valid1}, 32'd0);
    end

    // Recovery after reset
    @(posedge clk);
    #1;
    send(28'd4591, 14'd4591, 27'd29234, 8'h30, 14'd1, 14'd0, 1'b0, 1'b0, 14'd1, 14'd0, 1'b0, 1'b1, 1'b1);
    drain();

    repeat (3) @(negedge clk);
    chk("final_sb_empty", sb2.size() + sb1.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
